if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the LoongArch pipelined core. It feeds the decode stage (ID), which holds the decoder, regfile read and branch resolution.
- Holds the fetch PC and drives the synchronous instruction SRAM from a pre-IF next-PC.
- Hands {pc, inst} to ID under a valid/allowin handshake.
- Accepts branch redirects from ID and discards the wrong-path instruction.

Parameters:
- RESET_PC, 32'h1c000000, address of the first instruction fetched after reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, synchronous, active-high.
- ds_allowin  input  1  ID can accept an instruction this cycle.
- br_taken  input  1  ID redirect request; already qualified by ID valid.
- br_target  input  32  redirect target PC.
- fs_to_ds_valid  output  1  fs_pc/fs_inst valid for ID this cycle.
- fs_pc  output  32  PC of the instruction held in IF.
- fs_inst  output  32  instruction word held in IF.
- inst_sram_en  output  1  SRAM read enable.
- inst_sram_we  output  1  tied 0.
- inst_sram_addr  output  32  fetch address (= nextpc).
- inst_sram_wdata  output  32  tied 0.
- inst_sram_rdata  input  32  SRAM data; valid 1 cycle after an enabled request; holds its value while en=0.

Behaviour:
- State: fs_valid (1 bit), fs_pc (32 bits).
- Reset values:
  - fs_valid=0, fs_pc=RESET_PC-4, so seq_pc = RESET_PC.
  - Outputs while reset is high: fs_to_ds_valid=0, inst_sram_en=0.
- Pre-IF logic:
  - to_fs_valid = ~reset.
  - seq_pc = fs_pc + 4, modulo 2^32 (wrap 32'hfffffffc -> 0, no flag).
  - nextpc = br_taken ? br_target : seq_pc.
  - inst_sram_addr = nextpc.
  - inst_sram_en = to_fs_valid & fs_allowin.
- Handshake:
  - fs_ready_go = 1; the SRAM has a fixed 1-cycle latency.
  - fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin) | br_taken.
  - fs_to_ds_valid = fs_valid & fs_ready_go & ~br_taken.
  - Transfer to ID happens on a cycle with fs_to_ds_valid & ds_allowin.
- Update rule: when fs_allowin, fs_valid <= to_fs_valid and fs_pc <= nextpc. Otherwise both hold.
- Outputs: fs_inst = inst_sram_rdata; fs_pc is the registered fs_pc.
- Stall (ds_allowin=0, no branch):
  - fs_pc, fs_valid and inst_sram_en=0 hold.
  - The SRAM output holds, so fs_inst is stable until accepted.
- Redirect (br_taken=1):
  - Has priority over a stall.
  - The current IF instruction is cancelled: fs_to_ds_valid=0 that cycle.
  - The SRAM is requested at br_target.
  - The next cycle has fs_pc=br_target and fs_valid=1.
  - Latency: the target instruction is presented to ID 1 cycle after br_taken.
- br_taken with fs_valid=0: same as above; the target is still fetched.
- Reset asserted mid-operation:
  - The next edge returns all state to reset values.
  - Any in-flight instruction is dropped; nothing is presented to ID until the refetch of RESET_PC.
- First fetch: the cycle after reset falls, the SRAM is requested at RESET_PC; the following cycle has fs_valid=1, fs_pc=RESET_PC.
- Steady state with no stalls: one instruction per cycle, consecutive PCs +4.

Optional Feature:
- Macro: IF_ADEF_CHECK_EN.
- Defined:
  - Adds output fs_adef (1 bit) = fs_valid & (fs_pc[1:0] != 0).
  - When fs_adef=1, fs_inst is forced to 32'h03400000 (NOP) so ID decodes nothing harmful.
  - When nextpc[1:0] != 0, inst_sram_en=0 and no SRAM access is made; the PC still advances.
  - Reset value of fs_adef is 0.
- Undefined: no fs_adef port; PC bits [1:0] are ignored and fs_inst is always inst_sram_rdata.

Test Plan:
- Reset released, ds_allowin=1, SRAM returns mem[addr]:
  - First request is at 32'h1c000000.
  - fs_pc runs 1c000000, 1c000004, 1c000008 on consecutive cycles, with fs_to_ds_valid=1 after the first cycle.
- ds_allowin=0 for 3 cycles while fs_pc=1c000008:
  - fs_pc, fs_inst and fs_to_ds_valid=1 hold; inst_sram_en=0.
  - After release, 1c00000c follows one cycle later.
- br_taken=1, br_target=1c000100 while fs_pc=1c000010:
  - fs_to_ds_valid=0 that cycle and inst_sram_addr=1c000100.
  - Next cycle fs_pc=1c000100, valid=1.
- br_taken=1 coincident with ds_allowin=0: the redirect still occurs; fs_pc=target the next cycle.
- Reset asserted while fs_pc=1c000040: fs_valid=0 next cycle; after release the fetch restarts at 1c000000.
- IF_ADEF_CHECK_EN defined, br_target=1c000102: next cycle fs_adef=1, fs_inst=03400000, and the SRAM is not enabled for that address.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the fetch PC, drives the synchronous instruction SRAM
// from the pre-IF next PC and hands {pc, inst} to ID. Optional macro: IF_ADEF_CHECK_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
`ifdef IF_ADEF_CHECK_EN
    output logic        fs_adef,
`endif
    output logic        inst_sram_en,
    output logic        inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
);

    localparam int unsigned XLEN     = 32;
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] NOP_INST = 32'h03400000;

    logic            fs_valid;
    logic            to_fs_valid;
    logic            fs_ready_go;
    logic            fs_allowin;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] nextpc;
    logic            fetch_ok;

    // Pre-IF: next-PC selection, redirect wins over sequential flow
    always_comb begin
        to_fs_valid = ~reset;
        fs_ready_go = 1'b1;
        seq_pc      = fs_pc + PC_STEP;
        nextpc      = br_taken ? br_target : seq_pc;
        fs_allowin  = ~fs_valid | (fs_ready_go & ds_allowin) | br_taken;
    end

`ifdef IF_ADEF_CHECK_EN
    // Misaligned fetches never reach the SRAM; the faulting slot carries a NOP instead
    always_comb begin
        fetch_ok = (nextpc[1:0] == 2'b00);
        fs_adef  = ~reset & fs_valid & (fs_pc[1:0] != 2'b00);
        fs_inst  = fs_adef ? NOP_INST : inst_sram_rdata;
    end
`else
    always_comb begin
        fetch_ok = 1'b1;
        fs_inst  = inst_sram_rdata;
    end
`endif

    always_comb begin
        inst_sram_en    = to_fs_valid & fs_allowin & fetch_ok;
        inst_sram_we    = 1'b0;
        inst_sram_addr  = nextpc;
        inst_sram_wdata = '0;
        fs_to_ds_valid  = ~reset & fs_valid & fs_ready_go & ~br_taken;
    end

    // IF state: reset points seq_pc at RESET_PC so the first fetch needs no special case
    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid <= 1'b0;
            fs_pc    <= RESET_PC - PC_STEP;
        end else if (fs_allowin) begin
            fs_valid <= to_fs_valid;
            fs_pc    <= nextpc;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: an instruction-stream model (next PC owed to ID) checked
// every cycle, plus directed literal checks of the first fetch, stall, redirect and reset.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h1c000000;
    localparam logic [31:0] NOP_INST = 32'h03400000;

    logic        clk = 1'b0;
    logic        reset;
    logic        ds_allowin;
    logic        br_taken;
    logic [31:0] br_target;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        inst_sram_en;
    logic        inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata = 32'h0;
`ifdef IF_ADEF_CHECK_EN
    logic        fs_adef;
`endif

    int n_checks = 0;
    int n_errors = 0;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .ds_allowin      (ds_allowin),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_pc           (fs_pc),
        .fs_inst         (fs_inst),
`ifdef IF_ADEF_CHECK_EN
        .fs_adef         (fs_adef),
`endif
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h9e3779b9;
    endfunction

    // Synchronous SRAM: one-cycle latency, output holds while not enabled
    always @(posedge clk) if (inst_sram_en) inst_sram_rdata <= memf(inst_sram_addr);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic misaligned(input logic [31:0] a);
`ifdef IF_ADEF_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    // Model: exp_next is the PC owed to ID next; IF holds a valid instruction
    // on every cycle whose preceding edge saw reset low.
    logic [31:0] exp_next = RESET_PC;
    logic        prev_reset = 1'b1;

    initial begin
        logic        mv;
        logic        men;
        logic [31:0] maddr;
        forever begin
            @(negedge clk);
            mv  = !prev_reset;
            men = !reset && !(mv && !ds_allowin && !br_taken);
            maddr = br_taken ? br_target : (mv ? exp_next + 32'd4 : exp_next);
            if (misaligned(maddr)) men = 1'b0;
            chk("sram_we", {31'b0, inst_sram_we}, 32'h0);
            chk("sram_wdata", inst_sram_wdata, 32'h0);
            chk("to_ds_valid", {31'b0, fs_to_ds_valid}, {31'b0, !reset && mv && !br_taken});
            chk("sram_en", {31'b0, inst_sram_en}, {31'b0, men});
            if (!reset && (men || br_taken)) chk("sram_addr", inst_sram_addr, maddr);
            if (!reset && mv) begin
                chk("fs_pc", fs_pc, exp_next);
                chk("fs_inst", fs_inst, misaligned(exp_next) ? NOP_INST : memf(exp_next));
            end
            if (!reset && !mv) chk("fs_pc_idle", fs_pc, RESET_PC - 32'd4);
`ifdef IF_ADEF_CHECK_EN
            if (!reset) chk("fs_adef", {31'b0, fs_adef}, {31'b0, mv && misaligned(exp_next)});
`endif
            @(posedge clk);
            if (reset) exp_next = RESET_PC;
            else if (br_taken) exp_next = br_target;
            else if (mv && ds_allowin) exp_next = exp_next + 32'd4;
            prev_reset = reset;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; ds_allowin = 1'b1; br_taken = 1'b0; br_target = 32'h0;
        repeat (3) step();
        reset = 1'b0;
        at_neg();
        chk("first_req_en", {31'b0, inst_sram_en}, 32'h1);
        chk("first_req_addr", inst_sram_addr, 32'h1c000000);
        step(); at_neg();
        chk("pc0", fs_pc, 32'h1c000000);
        chk("pc0_valid", {31'b0, fs_to_ds_valid}, 32'h1);
        step(); at_neg(); chk("pc1", fs_pc, 32'h1c000004);
        step(); at_neg(); chk("pc2", fs_pc, 32'h1c000008);
        // stall for 3 cycles
        ds_allowin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("stall_pc", fs_pc, 32'h1c000008);
            chk("stall_inst", fs_inst, memf(32'h1c000008));
            chk("stall_valid", {31'b0, fs_to_ds_valid}, 32'h1);
            chk("stall_en", {31'b0, inst_sram_en}, 32'h0);
            step();
        end
        ds_allowin = 1'b1;
        at_neg(); chk("release_pc", fs_pc, 32'h1c000008);
        step(); at_neg(); chk("pc3", fs_pc, 32'h1c00000c);
        step(); at_neg(); chk("pc4", fs_pc, 32'h1c000010);
        // redirect
        br_taken = 1'b1; br_target = 32'h1c000100;
        at_neg();
        chk("br_cancel", {31'b0, fs_to_ds_valid}, 32'h0);
        chk("br_addr", inst_sram_addr, 32'h1c000100);
        step(); br_taken = 1'b0; at_neg();
        chk("br_pc", fs_pc, 32'h1c000100);
        chk("br_valid", {31'b0, fs_to_ds_valid}, 32'h1);
        // redirect during a stall
        ds_allowin = 1'b0; br_taken = 1'b1; br_target = 32'h1c000200;
        at_neg(); chk("br_stall_en", {31'b0, inst_sram_en}, 32'h1);
        step(); br_taken = 1'b0; at_neg();
        chk("br_stall_pc", fs_pc, 32'h1c000200);
        ds_allowin = 1'b1;
`ifdef IF_ADEF_CHECK_EN
        br_taken = 1'b1; br_target = 32'h1c000102;
        at_neg(); chk("adef_no_en", {31'b0, inst_sram_en}, 32'h0);
        step(); br_taken = 1'b0; at_neg();
        chk("adef_flag", {31'b0, fs_adef}, 32'h1);
        chk("adef_nop", fs_inst, 32'h03400000);
`endif
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            reset      = ($urandom_range(0, 99) == 0);
            ds_allowin = ($urandom_range(0, 3) != 0);
            br_taken   = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 7))
                0:       br_target = 32'hfffffff8;
                1:       br_target = 32'hfffffffc;
                2:       br_target = $urandom;
                default: br_target = $urandom & 32'hfffffffc;
            endcase
        end
        step();
        reset = 1'b0; ds_allowin = 1'b1; br_taken = 1'b0;
        // reset mid-operation
        br_taken = 1'b1; br_target = 32'h1c000040;
        step(); br_taken = 1'b0; at_neg();
        chk("pre_reset_pc", fs_pc, 32'h1c000040);
        step(); reset = 1'b1;
        at_neg(); chk("reset_valid", {31'b0, fs_to_ds_valid}, 32'h0);
        step(); reset = 1'b0;
        at_neg();
        chk("post_reset_valid", {31'b0, fs_to_ds_valid}, 32'h0);
        chk("post_reset_addr", inst_sram_addr, 32'h1c000000);
        step(); at_neg();
        chk("restart_pc", fs_pc, 32'h1c000000);
        step();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
